// File: rtl/intersection_phase_scheduler.sv
// Two-approach intersection scheduler: 1 s prescaler, phase timer, demand hold,
// programmable durations and registered lamp drive.
//
// state        | meaning
// CLEAR_TO_NS  | all red, clearance before NS is released
// NS_ARROW     | NS protected arrow plus green, EW red
// NS_GREEN     | NS green, EW red; held while EW has no demand
// NS_YELLOW    | NS yellow, EW red
// CLEAR_TO_EW  | all red, clearance before EW is released
// EW_ARROW     | EW protected arrow plus green, NS red
// EW_GREEN     | EW green, NS red; held while NS has no demand
// EW_YELLOW    | EW yellow, NS red
module intersection_phase_scheduler #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_DIV   = CLK_FREQ,
    parameter int DEF_ARROW  = 3,
    parameter int DEF_GREEN  = 8,
    parameter int DEF_YELLOW = 2,
    parameter int DEF_CLEAR  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [1:0] cfg_sel,
    input  logic [3:0] cfg_data,
    input  logic       ns_car,
    input  logic       ew_car,
    output logic       ns_green,
    output logic       ns_arrow,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       ew_green,
    output logic       ew_arrow,
    output logic       ew_yellow,
    output logic       ew_red,
    output logic [3:0] phase,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    // lamp vector order: ns {green, arrow, yellow, red}, ew {green, arrow, yellow, red}
    localparam logic [7:0] ALL_RED = 8'b0001_0001;

    typedef enum logic [3:0] {
        CLEAR_TO_NS = 4'd0,
        NS_ARROW    = 4'd1,
        NS_GREEN    = 4'd2,
        NS_YELLOW   = 4'd3,
        CLEAR_TO_EW = 4'd4,
        EW_ARROW    = 4'd5,
        EW_GREEN    = 4'd6,
        EW_YELLOW   = 4'd7
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q;
    logic [3:0]    timer_q, timer_d;
    logic [3:0]    dur_arrow, dur_green, dur_yellow, dur_clear;
    logic [3:0]    green_ld, yellow_ld, clear_ld;
    logic          ns_dem, ew_dem;
    logic          expire, changing, enter_ns, enter_ew;
    logic [7:0]    lamps_d, lamps_q;

    assign tick     = (pre_q == PRE_MAX);
    assign expire   = tick && (timer_q <= 4'd1);
    assign changing = (state_d != state_q);
    assign enter_ns = changing && (state_d == NS_ARROW || state_d == NS_GREEN);
    assign enter_ew = changing && (state_d == EW_ARROW || state_d == EW_GREEN);

    // A zero duration means one tick everywhere except the arrow, where it means skip.
    assign green_ld  = (dur_green  == 4'd0) ? 4'd1 : dur_green;
    assign yellow_ld = (dur_yellow == 4'd0) ? 4'd1 : dur_yellow;
    assign clear_ld  = (dur_clear  == 4'd0) ? 4'd1 : dur_clear;

    always_comb begin
        state_d = state_q;
        timer_d = tick ? (timer_q - 4'd1) : timer_q;
        case (state_q)
            CLEAR_TO_NS: if (expire) begin
                if (dur_arrow == 4'd0) begin
                    state_d = NS_GREEN;
                    timer_d = green_ld;
                end else begin
                    state_d = NS_ARROW;
                    timer_d = dur_arrow;
                end
            end
            NS_ARROW: if (expire) begin
                state_d = NS_GREEN;
                timer_d = green_ld;
            end
            NS_GREEN: if (expire) begin
                if (ew_dem) begin
                    state_d = NS_YELLOW;
                    timer_d = yellow_ld;
                end else begin
                    timer_d = green_ld;
                end
            end
            NS_YELLOW: if (expire) begin
                state_d = CLEAR_TO_EW;
                timer_d = clear_ld;
            end
            CLEAR_TO_EW: if (expire) begin
                if (dur_arrow == 4'd0) begin
                    state_d = EW_GREEN;
                    timer_d = green_ld;
                end else begin
                    state_d = EW_ARROW;
                    timer_d = dur_arrow;
                end
            end
            EW_ARROW: if (expire) begin
                state_d = EW_GREEN;
                timer_d = green_ld;
            end
            EW_GREEN: if (expire) begin
                if (ns_dem) begin
                    state_d = EW_YELLOW;
                    timer_d = yellow_ld;
                end else begin
                    timer_d = green_ld;
                end
            end
            EW_YELLOW: if (expire) begin
                state_d = CLEAR_TO_NS;
                timer_d = clear_ld;
            end
            default: begin
                state_d = CLEAR_TO_NS;
                timer_d = clear_ld;
            end
        endcase
    end

    // Lamps are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        lamps_d = ALL_RED;
        case (state_d)
            NS_ARROW:  lamps_d = 8'b1100_0001;
            NS_GREEN:  lamps_d = 8'b1000_0001;
            NS_YELLOW: lamps_d = 8'b0010_0001;
            EW_ARROW:  lamps_d = 8'b0001_1100;
            EW_GREEN:  lamps_d = 8'b0001_1000;
            EW_YELLOW: lamps_d = 8'b0001_0010;
            default:   lamps_d = ALL_RED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR_TO_NS;
            timer_q <= 4'(DEF_CLEAR);
            pre_q   <= '0;
            lamps_q <= ALL_RED;
            ns_dem  <= 1'b0;
            ew_dem  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pre_q   <= (tick || changing) ? '0 : pre_q + PW'(1);
            lamps_q <= lamps_d;
            ns_dem  <= enter_ns ? 1'b0 : (ns_dem | ns_car);
            ew_dem  <= enter_ew ? 1'b0 : (ew_dem | ew_car);
        end
    end

    // The timer only samples these at phase entry, so a write never disturbs a running phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dur_arrow  <= 4'(DEF_ARROW);
            dur_green  <= 4'(DEF_GREEN);
            dur_yellow <= 4'(DEF_YELLOW);
            dur_clear  <= 4'(DEF_CLEAR);
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    dur_arrow  <= cfg_data;
                2'd1:    dur_green  <= cfg_data;
                2'd2:    dur_yellow <= cfg_data;
                default: dur_clear  <= cfg_data;
            endcase
        end
    end

    assign {ns_green, ns_arrow, ns_yellow, ns_red,
            ew_green, ew_arrow, ew_yellow, ew_red} = lamps_q;
    assign phase = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with TICK_DIV = 4.
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic [3:0] cfg_data = 4'd0;
    logic       ns_car = 1'b1;
    logic       ew_car = 1'b1;
    logic       ns_green, ns_arrow, ns_yellow, ns_red;
    logic       ew_green, ew_arrow, ew_yellow, ew_red;
    logic [3:0] phase;
    logic       tick;

    int total = 0;
    int bad   = 0;

    intersection_phase_scheduler #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .ns_car(ns_car), .ew_car(ew_car),
        .ns_green(ns_green), .ns_arrow(ns_arrow), .ns_yellow(ns_yellow), .ns_red(ns_red),
        .ew_green(ew_green), .ew_arrow(ew_arrow), .ew_yellow(ew_yellow), .ew_red(ew_red),
        .phase(phase), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lamp_model(input logic [3:0] ph);
        case (ph)
            4'd1:    return 8'b1100_0001;
            4'd2:    return 8'b1000_0001;
            4'd3:    return 8'b0010_0001;
            4'd5:    return 8'b0001_1100;
            4'd6:    return 8'b0001_1000;
            4'd7:    return 8'b0001_0010;
            default: return 8'b0001_0001;
        endcase
    endfunction

    task automatic chk(input string ctx, input string item, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0d expected=%0d", ctx, item, obs, exp);
        end
    endtask

    task automatic check_cycle(input logic [3:0] ph, input int idx, input string ctx);
        chk(ctx, "phase", int'(phase), int'(ph));
        chk(ctx, "lamps", int'({ns_green, ns_arrow, ns_yellow, ns_red,
                                ew_green, ew_arrow, ew_yellow, ew_red}), int'(lamp_model(ph)));
        chk(ctx, "tick", int'(tick), (idx % 4 == 3) ? 1 : 0);
    endtask

    task automatic step(input logic [3:0] ph, input int idx0, input int cnt, input string ctx);
        for (int i = 0; i < cnt; i++) begin
            check_cycle(ph, idx0 + i, ctx);
            @(negedge clk);
        end
    endtask

    // Runs from cycle idx0 of a phase until it ends; expects exactly 'len' cycles in total.
    task automatic run_phase(input logic [3:0] ph, input int idx0, input int len, input string ctx);
        int n;
        n = idx0;
        while (phase == ph && n < len + 8) begin
            check_cycle(ph, n, ctx);
            n++;
            @(negedge clk);
        end
        chk(ctx, "length", n, len);
    endtask

    initial begin
        // Reset state and default sequence with demand on both approaches
        @(negedge clk);
        @(negedge clk);
        chk("reset", "lamps", int'({ns_green, ns_arrow, ns_yellow, ns_red,
                                    ew_green, ew_arrow, ew_yellow, ew_red}), 8'b0001_0001);
        chk("reset", "phase", int'(phase), 0);
        chk("reset", "tick", int'(tick), 0);
        rst = 1'b1;
        run_phase(4'd0, 0, 4,  "clr_ns0");
        run_phase(4'd1, 0, 12, "ns_arrow0");
        run_phase(4'd2, 0, 32, "ns_green0");
        run_phase(4'd3, 0, 8,  "ns_yellow0");
        run_phase(4'd4, 0, 4,  "clr_ew0");
        run_phase(4'd5, 0, 12, "ew_arrow0");
        run_phase(4'd6, 0, 32, "ew_green0");
        run_phase(4'd7, 0, 8,  "ew_yellow0");
        run_phase(4'd0, 0, 4,  "clr_ns1");

        // Green write coincident with NS_GREEN entry must not affect that entry
        step(4'd1, 0, 11, "ns_arrow1");
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 4'd5;
        check_cycle(4'd1, 11, "ns_arrow1");
        @(negedge clk);
        cfg_sel = 2'd1; cfg_data = 4'd2;
        check_cycle(4'd2, 0, "ns_green1");
        @(negedge clk);
        cfg_sel = 2'd0; cfg_data = 4'd0;
        check_cycle(4'd2, 1, "ns_green1");
        @(negedge clk);
        cfg_we = 1'b0;
        run_phase(4'd2, 2, 32, "ns_green1");
        run_phase(4'd3, 0, 8,  "ns_yellow1");
        run_phase(4'd4, 0, 4,  "clr_ew1");
        // Arrow skipped, new green of 2 ticks
        run_phase(4'd6, 0, 8,  "ew_green_skip");
        run_phase(4'd7, 0, 8,  "ew_yellow1");
        run_phase(4'd0, 0, 4,  "clr_ns2");
        run_phase(4'd2, 0, 8,  "ns_green_skip");
        run_phase(4'd3, 0, 8,  "ns_yellow2");
        run_phase(4'd4, 0, 4,  "clr_ew2");

        // Asynchronous reset in the middle of EW_GREEN
        step(4'd6, 0, 3, "ew_green_rst");
        rst = 1'b0;
        ew_car = 1'b0;
        #1;
        chk("midrst", "ew_green", int'(ew_green), 0);
        chk("midrst", "ew_red", int'(ew_red), 1);
        chk("midrst", "ns_red", int'(ns_red), 1);
        chk("midrst", "phase", int'(phase), 0);
        chk("midrst", "tick", int'(tick), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Defaults restored; NS green held while EW has no demand
        run_phase(4'd0, 0, 4,  "clr_ns3");
        run_phase(4'd1, 0, 12, "ns_arrow3");
        step(4'd2, 0, 74, "ns_hold");
        ew_car = 1'b1;
        check_cycle(4'd2, 74, "ns_hold");
        @(negedge clk);
        ew_car = 1'b0;
        run_phase(4'd2, 75, 96, "ns_hold");
        run_phase(4'd3, 0, 8,  "ns_yellow3");

        // Safety invariants under random sensors and configuration writes
        for (int i = 0; i < 10000; i++) begin
            ns_car   = 1'($urandom_range(0, 1));
            ew_car   = 1'($urandom_range(0, 1));
            cfg_we   = ($urandom_range(0, 15) == 0);
            cfg_sel  = 2'($urandom_range(0, 3));
            cfg_data = 4'($urandom_range(0, 15));
            chk("safety", "ns_one_group", int'(ns_red) + int'(ns_yellow) + int'(ns_green), 1);
            chk("safety", "ew_one_group", int'(ew_red) + int'(ew_yellow) + int'(ew_green), 1);
            chk("safety", "no_conflict", int'((ns_green | ns_yellow) & (ew_green | ew_yellow)), 0);
            chk("safety", "arrow_w_green", int'((ns_arrow & ~ns_green) | (ew_arrow & ~ew_green)), 0);
            chk("safety", "lamps_vs_phase", int'({ns_green, ns_arrow, ns_yellow, ns_red,
                                                  ew_green, ew_arrow, ew_yellow, ew_red}),
                int'(lamp_model(phase)));
            @(negedge clk);
        end
        cfg_we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
